uart_word_tx: RTL and testbench

- Downstream consumer of the per-channel read-address/RD-strobe sequencer.
- One instance per UART channel.
- On each RD rising edge it latches the RAM output word addressed by RdAdr and serialises it LSB-first as an asynchronous frame (start, data, optional parity, stop).
- Counts words per packet, flags address-sequence errors and overruns, and pulses pkt_done after the last word of a packet.

---
 rtl/comm_pkg.sv | 21 ++
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_word_tx.sv | 163 ++++++++++++++++
 tb/tb_uart_word_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the per-channel UART word transmitter.
package comm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int unsigned WORDS_PER_PKT    = 20;
  localparam int unsigned RD_PERIOD        = 64;
  localparam int unsigned CLKS_PER_BIT_DEF = 4;

  // Counter width for a 0..n-1 range; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter; o_tc marks the last cycle of the current serial bit.
module uart_baud_cnt
  import comm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_tc
);

  localparam int unsigned CW = cnt_w(CLKS_PER_BIT);

  logic [CW-1:0] r_cnt;

  assign o_tc = i_run && (r_cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!i_run || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_tx.sv
// Latches one RAM word per RD rising edge and sends it as an async serial frame;
// tracks the word index per packet and reports address errors and overruns.
module uart_word_tx
  import comm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned WORDS        = WORDS_PER_PKT,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic [4:0]        rd_adr,
  input  logic [DATA_W-1:0] ram_q,
  output logic              tx,
  output logic              busy,
  output logic              frame_done,
  output logic              pkt_done,
  output logic              adr_err,
  output logic              overrun,
  input  logic              clr_err
);

  localparam int unsigned BW = cnt_w(DATA_W);

  uart_state_t       r_state;
  logic              r_rd_q;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic [BW-1:0]     r_bit;
  logic [4:0]        r_idx;
  logic              r_last;
  logic              r_tx;
  logic              r_busy;
  logic              r_fd;
  logic              r_pd;
  logic              r_adr_err;
  logic              r_ovr;

  logic              w_start;
  logic              w_tc;
  logic [4:0]        w_base;
  logic              w_base_last;
  logic [4:0]        w_acc_next;
  logic [4:0]        w_drop_next;
  logic [DATA_W-1:0] w_shift_nx;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .i_run(r_state != IDLE),
    .o_tc (w_tc)
  );

  assign w_start = rd & ~r_rd_q;

  always_comb begin
    w_base      = (rd_adr == '0) ? '0 : r_idx;
    w_base_last = (w_base == 5'(WORDS - 1));
    w_acc_next  = w_base_last ? '0 : w_base + 5'd1;
    w_drop_next = (r_idx == 5'(WORDS - 1)) ? '0 : r_idx + 5'd1;
    w_shift_nx  = r_shift >> 1;
  end

  // The index advances at accept rather than at stop; r_last remembers whether
  // the frame in flight ends the packet, so dropped words cannot fake pkt_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_rd_q    <= 1'b0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit     <= '0;
      r_idx     <= '0;
      r_last    <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_fd      <= 1'b0;
      r_pd      <= 1'b0;
      r_adr_err <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_rd_q <= rd;
      r_fd   <= 1'b0;
      r_pd   <= 1'b0;
      if (clr_err) begin
        r_adr_err <= 1'b0;
        r_ovr     <= 1'b0;
      end
      if (w_start && r_busy) begin
        r_ovr <= 1'b1;
        r_idx <= w_drop_next;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_shift <= ram_q;
            r_par   <= (^ram_q) ^ (PARITY_ODD != 0);
            if (rd_adr != r_idx) r_adr_err <= 1'b1;
            r_idx   <= w_acc_next;
            r_last  <= w_base_last;
            r_state <= START;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_tc) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_bit   <= '0;
          end
        end
        DATA: begin
          if (w_tc) begin
            if (r_bit == BW'(DATA_W - 1)) begin
              if (PARITY_EN != 0) begin
                r_state <= PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_shift <= w_shift_nx;
              r_tx    <= w_shift_nx[0];
              r_bit   <= r_bit + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_tc) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
        end
        STOP: begin
          if (w_tc) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_fd    <= 1'b1;
            r_pd    <= r_last;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_fd;
  assign pkt_done   = r_pd;
  assign adr_err    = r_adr_err;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench: table-driven packet plus hand-written corner sequences,
// with a frame-decoding scoreboard on the default-parameter instance.
module tb_uart_word_tx;

  typedef struct {
    logic [7:0] d;
    logic       pkt;
  } exp_t;

  typedef struct {
    logic [4:0] adr;
    logic [7:0] d;
    logic       pkt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd = 1'b0;
  logic [4:0] rd_adr = '0;
  logic [7:0] ram_q = '0;
  logic       clr_err = 1'b0;

  logic tx0, busy0, fd0, pd0, ae0, ov0;
  logic tx1, busy1, fd1, pd1, ae1, ov1;
  logic tx2, busy2, fd2, pd2, ae2, ov2;

  int   n_pass = 0;
  int   n_tot = 0;
  int   pkt_cnt = 0;
  logic mon_en = 1'b0;
  exp_t sb[$];
  vec_t tbl[20];

  always #5 clk = ~clk;

  uart_word_tx dut0 (
    .clk(clk), .rst(rst), .rd(rd), .rd_adr(rd_adr), .ram_q(ram_q),
    .tx(tx0), .busy(busy0), .frame_done(fd0), .pkt_done(pd0),
    .adr_err(ae0), .overrun(ov0), .clr_err(clr_err)
  );

  uart_word_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst(rst), .rd(rd), .rd_adr(rd_adr), .ram_q(ram_q),
    .tx(tx1), .busy(busy1), .frame_done(fd1), .pkt_done(pd1),
    .adr_err(ae1), .overrun(ov1), .clr_err(clr_err)
  );

  uart_word_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .rst(rst), .rd(rd), .rd_adr(rd_adr), .ram_q(ram_q),
    .tx(tx2), .busy(busy2), .frame_done(fd2), .pkt_done(pd2),
    .adr_err(ae2), .overrun(ov2), .clr_err(clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] adr, input logic [7:0] d, input bit push, input logic pkt);
    exp_t e;
    if (push) begin
      e.d = d;
      e.pkt = pkt;
      sb.push_back(e);
    end
    rd = 1'b1;
    rd_adr = adr;
    ram_q = d;
    repeat (4) @(negedge clk);
    rd = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  initial forever begin
    @(negedge clk);
    if (pd0) pkt_cnt++;
  end

  // Scoreboard monitor: first negedge with busy is cycle 0 of a 40-cycle frame.
  initial begin
    logic [9:0] fb;
    logic [7:0] got;
    logic       ok;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (mon_en && busy0) begin
        ok = 1'b1;
        got = '0;
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          e.d = '0;
          e.pkt = 1'b0;
        end else begin
          e = sb.pop_front();
        end
        fb = {1'b1, e.d, 1'b0};
        for (int c = 0; c < 40; c++) begin
          if (c > 0) @(negedge clk);
          if (tx0 !== fb[c/4] || busy0 !== 1'b1 || fd0 !== 1'b0) ok = 1'b0;
          if ((c % 4) == 2 && c >= 4 && c < 36) got[c/4 - 1] = tx0;
        end
        @(negedge clk);
        chk("frame_data", 32'(got), 32'(e.d));
        chk("frame_shape", 32'(ok), 1);
        chk("frame_end", {30'd0, busy0, fd0}, 32'b01);
        chk("pkt_done", 32'(pd0), 32'(e.pkt));
      end
    end
  end

  initial begin
    int pc;
    logic stay_idle;
    for (int i = 0; i < 20; i++) begin
      tbl[i].adr = 5'(i);
      tbl[i].d   = 8'(i * 13 + 1);
      tbl[i].pkt = (i == 19);
    end

    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tx", 32'(tx0), 1);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_fd", 32'(fd0), 0);
    chk("rst_pd", 32'(pd0), 0);
    chk("rst_adr_err", 32'(ae0), 0);
    chk("rst_overrun", 32'(ov0), 0);

    // Mid-frame async reset
    rd = 1'b1; rd_adr = '0; ram_q = 8'h00;
    repeat (4) @(negedge clk);
    rd = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", 32'(busy0), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx0), 1);
    chk("async_rst_busy", 32'(busy0), 0);
    @(negedge clk);
    rst = 1'b1;
    stay_idle = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || fd0 !== 1'b0) stay_idle = 1'b0;
    end
    chk("post_rst_quiet", 32'(stay_idle), 1);

    mon_en = 1'b1;
    send(5'd0, 8'hA5, 1'b1, 1'b0);

    do_reset();
    pkt_cnt = 0;
    for (int i = 0; i < 20; i++) send(tbl[i].adr, tbl[i].d, 1'b1, tbl[i].pkt);
    chk("pkt_count", 32'(pkt_cnt), 1);
    chk("pkt_adr_err", 32'(ae0), 0);

    // Overrun: second edge 20 cycles after the first is dropped
    rd = 1'b1; rd_adr = 5'd0; ram_q = 8'h3C;
    sb.push_back('{d: 8'h3C, pkt: 1'b0});
    repeat (4) @(negedge clk);
    rd = 1'b0;
    repeat (16) @(negedge clk);
    rd = 1'b1; rd_adr = 5'd1; ram_q = 8'hFF;
    repeat (4) @(negedge clk);
    rd = 1'b0;
    repeat (60) @(negedge clk);
    chk("overrun_set", 32'(ov0), 1);
    chk("overrun_no_adr_err", 32'(ae0), 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("overrun_cleared", 32'(ov0), 0);
    send(5'd2, 8'h5A, 1'b1, 1'b0);
    chk("post_drop_aligned", 32'(ae0), 0);

    // Address error: sequence 0,1,3
    do_reset();
    send(5'd0, 8'h11, 1'b1, 1'b0);
    send(5'd1, 8'h22, 1'b1, 1'b0);
    chk("adr_ok_seq", 32'(ae0), 0);
    send(5'd3, 8'h33, 1'b1, 1'b0);
    chk("adr_err_set", 32'(ae0), 1);

    // Parity on the parity-enabled instances
    do_reset();
    sb.push_back('{d: 8'h07, pkt: 1'b0});
    rd = 1'b1; rd_adr = 5'd0; ram_q = 8'h07;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (c == 3) rd = 1'b0;
      if (c == 38) begin
        chk("parity_even", 32'(tx1), 1);
        chk("parity_odd", 32'(tx2), 0);
      end
      if (c == 43) chk("par_frame_busy", {30'd0, busy1, fd1}, 32'b10);
      if (c == 44) chk("par_frame_done", {30'd0, busy1, fd1}, 32'b01);
    end

    pc = 0;
    while (sb.size() != 0 && pc < 200) begin
      @(negedge clk);
      pc++;
    end
    chk("sb_drain", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
